// File: rtl/uart_word_ctrl.sv
// uart_word_ctrl: CPU-side word initiator for the byte-level UART unit.
// Splits one 32-bit request into BYTES little-endian uart_go/uart_done byte
// transactions and assembles the received bytes back into req_rdata.
// Optional feature macro: UART_TIMEOUT_EN (abort a byte wait after TIMEOUT
// cycles and complete the request with err=1).
module uart_word_ctrl #(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_wr,
  input  logic [31:0] req_wdata,
  output logic        req_ack,
  output logic [31:0] req_rdata,
  output logic        busy,
  output logic        err,
  output logic        uart_go,
  output logic        rors,
  output logic [7:0]  txdata,
  input  logic [7:0]  rxdata,
  input  logic        uart_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] LAST = 2'(BYTES - 1);

  state_t      state_reg;
  logic        wr_q_reg;
  logic [23:0] wbuf_reg;   // bytes still to be sent after the one on txdata
  logic [31:0] rbuf_reg;
  logic [1:0]  cnt_reg;
  logic [31:0] rbuf_next;  // rbuf with the byte arriving this cycle merged in

`ifdef UART_TIMEOUT_EN
  localparam logic [31:0] TLIMIT = 32'(TIMEOUT - 1);
  logic [31:0] tcnt_reg;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign err = 1'b0;
`endif

  // Per-lane merge of the received byte into the read buffer (reads only).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign rbuf_next[8*gi +: 8] = (!wr_q_reg && cnt_reg == LANE) ? rxdata
                                                                 : rbuf_reg[8*gi +: 8];
  end

  assign busy = (state_reg != IDLE);

  // Request sequencer with registered UART-side and core-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      wr_q_reg  <= 1'b0;
      wbuf_reg  <= '0;
      rbuf_reg  <= '0;
      cnt_reg   <= '0;
      uart_go   <= 1'b0;
      rors      <= 1'b0;
      txdata    <= '0;
      req_ack   <= 1'b0;
      req_rdata <= '0;
`ifdef UART_TIMEOUT_EN
      tcnt_reg  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      uart_go <= 1'b0;
      req_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            wr_q_reg  <= req_wr;
            wbuf_reg  <= req_wdata[31:8];
            rbuf_reg  <= '0;
            cnt_reg   <= '0;
            uart_go   <= 1'b1;
            rors      <= req_wr;
            txdata    <= req_wdata[7:0];
            state_reg <= ISSUE;
`ifdef UART_TIMEOUT_EN
            err       <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
`ifdef UART_TIMEOUT_EN
          tcnt_reg  <= '0;
`endif
        end
        WAIT: begin
          if (uart_done) begin
            rbuf_reg <= rbuf_next;
            if (cnt_reg == LAST) begin
              req_ack   <= 1'b1;
              req_rdata <= rbuf_next;
              state_reg <= ACK;
            end else begin
              cnt_reg   <= cnt_reg + 2'd1;
              wbuf_reg  <= wbuf_reg >> 8;
              txdata    <= wbuf_reg[7:0];
              uart_go   <= 1'b1;
              state_reg <= ISSUE;
            end
          end
`ifdef UART_TIMEOUT_EN
          else if (tcnt_reg == TLIMIT) begin
            // Give up: report what arrived so far, missing bytes stay zero.
            req_ack   <= 1'b1;
            req_rdata <= rbuf_reg;
            err       <= 1'b1;
            state_reg <= ACK;
          end else begin
            tcnt_reg  <= tcnt_reg + 32'd1;
          end
`endif
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Self-checking bench for uart_word_ctrl: a 4-byte instance with a UART
// response model and scoreboards for uart_go bytes and req_ack results, plus
// a 1-byte instance for the single-byte latency case.
module tb_uart_word_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, req_wr;
  logic [31:0] req_wdata;
  logic        req_ack, busy, err, uart_go, rors;
  logic [31:0] req_rdata;
  logic [7:0]  txdata, rxdata;
  logic        m_done, spur_done, uart_done;
  assign uart_done = m_done | spur_done;

  logic        req1, req_wr1;
  logic [31:0] req_wdata1;
  logic        req_ack1, busy1, err1, go1, rors1, done1;
  logic [31:0] req_rdata1;
  logic [7:0]  txdata1, rxdata1;

  int n_checks = 0;
  int n_pass   = 0;

  uart_word_ctrl #(.BYTES(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rdata(req_rdata), .busy(busy), .err(err),
    .uart_go(uart_go), .rors(rors), .txdata(txdata), .rxdata(rxdata),
    .uart_done(uart_done)
  );

  uart_word_ctrl #(.BYTES(1), .TIMEOUT(100)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_wr(req_wr1), .req_wdata(req_wdata1),
    .req_ack(req_ack1), .req_rdata(req_rdata1), .busy(busy1), .err(err1),
    .uart_go(go1), .rors(rors1), .txdata(txdata1), .rxdata(rxdata1),
    .uart_done(done1)
  );

  typedef struct packed {logic rors; logic [7:0] tx;} go_t;
  typedef struct packed {logic [31:0] rdata; logic err;} ack_t;
  go_t  exp_go[$];
  ack_t exp_ack[$];
  go_t  exp_hold;

  // UART model for the 4-byte instance: done m_delay cycles after each go
  // (m_delay==0 means never respond), returning bytes from m_resp.
  int         m_delay = 1;
  int         m_left  = 0;
  bit         m_active = 1'b0;
  int         m_dones = 0;
  logic [7:0] m_resp[$];

  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    rxdata = 8'($urandom);
    if (rst) begin
      m_active = 1'b0;
    end else begin
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          rxdata   = (m_resp.size() > 0) ? m_resp.pop_front() : 8'h00;
          m_dones++;
        end
      end
      if (uart_go && m_delay > 0) begin
        m_active = 1'b1;
        m_left   = m_delay;
      end
    end
  end

  // UART model for the 1-byte instance: zero-wait done returning 0x5A.
  bit act1 = 1'b0;
  int go1_cnt = 0;
  always @(posedge clk) begin
    #1;
    done1   = 1'b0;
    rxdata1 = 8'($urandom);
    if (rst) begin
      act1 = 1'b0;
    end else begin
      if (act1) begin
        act1    = 1'b0;
        done1   = 1'b1;
        rxdata1 = 8'h5A;
      end
      if (go1) act1 = 1'b1;
    end
  end

  always @(negedge clk) if (go1) go1_cnt++;

  // Byte scoreboard: every uart_go must match the next expected byte, and
  // rors/txdata must still hold that byte when uart_done arrives.
  always @(negedge clk) begin
    if (uart_go) begin
      n_checks++;
      if (exp_go.size() == 0) begin
        $display("FAIL go_unexpected: got rors=%0b txdata=%h, required no uart_go", rors, txdata);
      end else begin
        exp_hold = exp_go.pop_front();
        if ({rors, txdata} !== exp_hold) $display("FAIL go_byte: got rors=%0b txdata=%h, required rors=%0b txdata=%h", rors, txdata, exp_hold.rors, exp_hold.tx);
        else n_pass++;
      end
    end
    if (uart_done && busy) begin
      n_checks++;
      if ({rors, txdata} !== exp_hold) $display("FAIL go_hold: got rors=%0b txdata=%h, required rors=%0b txdata=%h", rors, txdata, exp_hold.rors, exp_hold.tx);
      else n_pass++;
    end
  end

  // Completion scoreboard: one line per finished transaction.
  always @(negedge clk) begin
    if (req_ack) begin
      ack_t a;
      $display("ack: rdata=%h err=%0b busy=%0b", req_rdata, err, busy);
      n_checks++;
      if (exp_ack.size() == 0) begin
        $display("FAIL ack_unexpected: got req_ack with rdata=%h, required none", req_rdata);
      end else begin
        a = exp_ack.pop_front();
        if ({req_rdata, err, busy} !== {a.rdata, a.err, 1'b1})
          $display("FAIL ack_data: got rdata=%h err=%0b busy=%0b, required rdata=%h err=%0b busy=1", req_rdata, err, busy, a.rdata, a.err);
        else n_pass++;
      end
    end
  end

  task automatic push_req(input logic wr, input logic [31:0] wd, input logic [31:0] rd, input int nb);
    for (int i = 0; i < nb; i++) exp_go.push_back(go_t'{rors: wr, tx: wd[8*i +: 8]});
    exp_ack.push_back(ack_t'{rdata: (wr ? 32'h0 : rd), err: 1'b0});
  endtask

  // Issue one request (called at posedge+1) and count edges until req_ack.
  task automatic run_req(input logic wr, input logic [31:0] wd, output int lat);
    req = 1'b1; req_wr = wr; req_wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; req_wdata = $urandom;
    lat = 1;
    while (!req_ack && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (!req_ack) $display("FAIL ack_wait: got no req_ack in %0d cycles, required req_ack", lat);
    else n_pass++;
  endtask

  task automatic check_lat(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got latency %0d, required %0d", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({uart_go, rors, txdata, req_ack, req_rdata, busy, err} !== '0)
      $display("FAIL reset_outputs: got go=%0b rors=%0b tx=%h ack=%0b rdata=%h busy=%0b err=%0b, required all 0", uart_go, rors, txdata, req_ack, req_rdata, busy, err);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({go1, rors1, txdata1, req_ack1, req_rdata1, busy1, err1, busy} !== '0)
      $display("FAIL reset_idle: got busy=%0b busy1=%0b rdata1=%h, required all 0", busy, busy1, req_rdata1);
    else n_pass++;
  endtask

  task automatic test_write();
    int lat;
    m_delay = 20;
    push_req(1'b1, 32'hDEADBEEF, 32'h0, 4);
    run_req(1'b1, 32'hDEADBEEF, lat);
    check_lat("write_latency", lat, 85);
    n_checks++;
    if (exp_go.size() != 0) $display("FAIL write_go_count: got %0d bytes outstanding, required 0", exp_go.size());
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL write_busy_after: got busy=%0b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_read();
    int lat;
    m_delay = 3;
    m_resp = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_req(1'b0, 32'h0BADF00D, 32'h44332211, 4);
    run_req(1'b0, 32'h0BADF00D, lat);
    check_lat("read_latency", lat, 17);
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat;
    m_delay = 10;
    push_req(1'b1, 32'hCAFEF00D, 32'h0, 4);
    fork
      run_req(1'b1, 32'hCAFEF00D, lat);
      begin
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1; req_wr = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        req = 1'b0;
      end
    join
    check_lat("busy_ignore_latency", lat, 45);
    @(posedge clk); #1;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL spurious_done: got busy=%0b, required 0", busy);
    else n_pass++;
    m_delay = 2;
    m_resp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_req(1'b0, 32'h0, 32'hDDCCBBAA, 4);
    run_req(1'b0, 32'h0, lat);
    check_lat("after_spurious_latency", lat, 13);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int start;
    m_delay = 3;
    m_resp = '{8'h01, 8'h02, 8'h03, 8'h04};
    start = m_dones;
    push_req(1'b0, 32'h0, 32'h04030201, 4);
    req = 1'b1; req_wr = 1'b0; req_wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (m_dones - start < 2 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (m_dones - start < 2) $display("FAIL reset_mid_progress: got %0d dones, required 2", m_dones - start);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_go.delete();
    exp_ack.delete();
    m_resp.delete();
    n_checks++;
    if ({uart_go, rors, txdata, req_ack, req_rdata, busy, err} !== '0)
      $display("FAIL reset_mid_outputs: got go=%0b tx=%h ack=%0b rdata=%h busy=%0b, required all 0", uart_go, txdata, req_ack, req_rdata, busy);
    else n_pass++;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    m_resp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    push_req(1'b0, 32'h0, 32'hA1B2C3D4, 4);
    run_req(1'b0, 32'h0, lat);
    check_lat("reset_mid_read_latency", lat, 17);
    @(posedge clk); #1;
  endtask

  task automatic test_bytes1();
    int lat;
    int g0;
    logic [31:0] exp_q[$];
    g0 = go1_cnt;
    exp_q.push_back(32'h0000005A);
    req1 = 1'b1; req_wr1 = 1'b0; req_wdata1 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req1 = 1'b0;
    lat = 1;
    while (!req_ack1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_lat("bytes1_latency", lat, 3);
    n_checks++;
    if (req_rdata1 !== exp_q[0]) $display("FAIL bytes1_rdata: got %h, required %h", req_rdata1, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    $display("ack1: rdata=%h", req_rdata1);
    @(posedge clk); #1;
    n_checks++;
    if (go1_cnt - g0 != 1 || busy1 !== 1'b0) $display("FAIL bytes1_go_count: got %0d pulses busy1=%0b, required 1 pulse busy1=0", go1_cnt - g0, busy1);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int lat;
    m_delay = 0;
`ifdef UART_TIMEOUT_EN
    exp_go.push_back(go_t'{rors: 1'b1, tx: 8'h78});
    exp_ack.push_back(ack_t'{rdata: 32'h0, err: 1'b1});
    run_req(1'b1, 32'h12345678, lat);
    check_lat("timeout_latency", lat, 102);
    @(posedge clk); #1;
    m_delay = 1;
    m_resp = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_req(1'b0, 32'h0, 32'h40302010, 4);
    run_req(1'b0, 32'h0, lat);
    check_lat("after_timeout_latency", lat, 9);
`else
    begin
      int busy_cycles;
      busy_cycles = 0;
      exp_go.push_back(go_t'{rors: 1'b1, tx: 8'h78});
      req = 1'b1; req_wr = 1'b1; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (busy === 1'b1) busy_cycles++;
        @(posedge clk); #1;
      end
      n_checks++;
      if (busy_cycles != 1000) $display("FAIL no_timeout_busy: got %0d busy cycles, required 1000", busy_cycles);
      else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_go.delete();
      n_checks++;
      if (busy !== 1'b0) $display("FAIL no_timeout_recover: got busy=%0b, required 0", busy);
      else n_pass++;
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_wdata = 32'h0; spur_done = 1'b0;
    req1 = 1'b0; req_wr1 = 1'b0; req_wdata1 = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_bytes1();
    test_reset_mid();
    test_timeout();
    n_checks++;
    if (exp_go.size() != 0 || exp_ack.size() != 0)
      $display("FAIL scoreboard_drain: got %0d bytes and %0d acks outstanding, required 0", exp_go.size(), exp_ack.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_word_ctrl.md
# uart_word_ctrl

CPU-side initiator for the byte-level UART unit: converts one 32-bit input or output request from the core into a sequence of `uart_go`/`uart_done` byte transactions, and assembles or disassembles the data word. It sits between the core's I/O execution stage and `uart_unit`. It drives `uart_go`, `rors` and `txdata`, and consumes `uart_done` and `rxdata`.

## Interface
- `BYTES`, default 4: bytes per word transfer; legal values 1..4.
- `TIMEOUT`, default 1000000: cycles to wait for `uart_done` before aborting. Used only with `UART_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: one-cycle request pulse from the core; accepted only while `busy`=0.
- `req_wr` in 1: 1 = output word (send), 0 = input word (read); sampled with `req`.
- `req_wdata` in 32: word to send; sampled with `req`.
- `req_ack` out 1: one-cycle completion pulse.
- `req_rdata` out 32: assembled input word; valid in the `req_ack` cycle and held until the next accepted request.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: timeout abort flag; valid with `req_ack`.
- `uart_go` out 1: one-cycle start pulse to `uart_unit`.
- `rors` out 1: 1 = send, 0 = read; held stable from the `uart_go` cycle until `uart_done`.
- `txdata` out 8: byte to send; held stable with `rors`.
- `rxdata` in 8: received byte; valid in the `uart_done` cycle.
- `uart_done` in 1: one-cycle completion pulse from `uart_unit`.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - On `req`=1: latch `req_wr` into `wr_q` and `req_wdata` into `wbuf`; clear `rbuf` and `cnt`; go to ISSUE.
- ISSUE:
  - `uart_go`=1 for exactly one cycle, with `rors`=`wr_q` and `txdata`=`wbuf[7:0]`; go to WAIT.
- WAIT:
  - Hold `rors` and `txdata`.
  - On `uart_done`: if reading, write `rxdata` into `rbuf[8*cnt +: 8]`.
  - If `cnt`==`BYTES-1`, go to ACK.
  - Otherwise `cnt`++, shift `wbuf` right by 8, and go to ISSUE.
- ACK:
  - `req_ack`=1 for one cycle; `req_rdata`=`rbuf` (zero for a write); `busy` stays high this cycle; go to IDLE.
- Byte order is little-endian: byte 0 (bits [7:0]) is transferred first.
- When `BYTES`<4, the unused upper bytes of `req_rdata` are zero and the upper bytes of `req_wdata` are never sent.
- `uart_done` is ignored outside WAIT; a spurious pulse has no effect.
- `req` is ignored while `busy`=1 and is not queued.
- A `req` in the first cycle back in IDLE (the cycle after `req_ack`) is accepted.

## Timing
- Reset values: `uart_go`=0, `rors`=0, `txdata`=0, `req_ack`=0, `req_rdata`=0, `busy`=0, `err`=0; state IDLE, `cnt`=0.
- Request handshake:
  - `req` sampled at edge E; `busy`=1 and `uart_go`=1 in the cycle after E.
  - `busy`=1 persists through the `req_ack` cycle.
- Per byte:
  - 1 ISSUE cycle, then WAIT until `uart_done`.
  - The next `uart_go` is in the cycle after `uart_done`.
- `req_ack` is in the cycle after the last `uart_done`.
- Minimum total latency with zero-wait `uart_done` (done in the first WAIT cycle): 2·`BYTES`+1 cycles from acceptance to `req_ack`.
- Reset mid-transaction:
  - Abort immediately to IDLE with no `req_ack`; `rbuf` is discarded.
  - `uart_unit` shares the reset (integrator inverts for `rstn`) so no stale `uart_done` arrives.

## Configuration
- `UART_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT` without `uart_done`, go to ACK with `err`=1.
  - Partially received bytes stay in `req_rdata`; unreceived bytes read as zero.
  - `err` clears on the next accepted request.
- `UART_TIMEOUT_EN` not defined:
  - No counter; WAIT lasts indefinitely.
  - `err` is tied to 0.

## Test plan
- Write 0xDEADBEEF; model raises `uart_done` 20 cycles after each `uart_go`.
  - Expect four `uart_go` pulses with `rors`=1 and `txdata` EF, BE, AD, DE in that order.
  - Expect `req_ack` 1 cycle after the 4th done, then `busy`=0.
- Read; model returns 0x11, 0x22, 0x33, 0x44.
  - Expect `rors`=0 throughout and `req_rdata`=0x44332211 with `req_ack`.
- Issue `req` while busy and pulse `uart_done` while IDLE.
  - Expect no extra `uart_go`, no state change, and the original transfer completes normally.
- Assert `rst` after 2 bytes of a read.
  - Expect all outputs 0 and no `req_ack`.
  - A new read of 0xA1B2C3D4 then returns exactly 0xA1B2C3D4.
- `BYTES`=1: read 0x5A.
  - Expect one `uart_go` and `req_rdata`=0x0000005A; minimum latency is 3 cycles.
- Timeout, `TIMEOUT`=100, model never responds:
  - With `UART_TIMEOUT_EN`: `req_ack`=1 and `err`=1 exactly 100 WAIT cycles after `uart_go`.
  - Without the macro: `busy` stays 1 for 1000 cycles.
